// File: rtl/frogger_scan_obstacles.sv
// VGA scan-position tracker with one rightward-moving car and one leftward-moving log.
// Re-times the incoming syncs and flags the pixels whose tile matches either obstacle.
module frogger_scan_obstacles #(
    parameter int c_TOTAL_COLS     = 800,
    parameter int c_TOTAL_ROWS     = 525,
    parameter int c_CAR_SPEED      = 1,
    parameter int c_CAR_MAX_X      = 14,
    parameter int c_CAR_SLOW_COUNT = 4000000,
    parameter int c_CAR_INIT_X     = 0,
    parameter int c_CAR_INIT_Y     = 11,
    parameter int c_LOG_SPEED      = 1,
    parameter int c_LOG_MIN_X      = 0,
    parameter int c_LOG_SLOW_COUNT = 4200000,
    parameter int c_LOG_INIT_X     = 13,
    parameter int c_LOG_INIT_Y     = 1
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_HSync,
    input  logic       i_VSync,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic [4:0] o_Col_Count_Div,
    output logic [4:0] o_Row_Count_Div,
    output logic [5:0] o_Car_X,
    output logic [5:0] o_Car_Y,
    output logic [5:0] o_Log_X,
    output logic [5:0] o_Log_Y,
    output logic       o_Car_Draw,
    output logic       o_Log_Draw
);

    localparam int CarCntW = ($clog2(c_CAR_SLOW_COUNT) > 23) ? $clog2(c_CAR_SLOW_COUNT) : 23;
    localparam int LogCntW = ($clog2(c_LOG_SLOW_COUNT) > 23) ? $clog2(c_LOG_SLOW_COUNT) : 23;

    logic               hsync_q, vsync_q;
    logic [9:0]         col_q, col_d, row_q, row_d;
    logic [CarCntW-1:0] car_cnt_q, car_cnt_d;
    logic [LogCntW-1:0] log_cnt_q, log_cnt_d;
    logic [5:0]         car_x_q, car_x_d, log_x_q, log_x_d;
    logic               frame_start;

    assign frame_start = i_VSync & ~vsync_q;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end else if (col_q == 10'(c_TOTAL_COLS - 1)) begin
            col_d = '0;
            row_d = (row_q == 10'(c_TOTAL_ROWS - 1)) ? '0 : row_q + 10'd1;
        end else begin
            col_d = col_q + 10'd1;
        end
    end

    always_comb begin
        car_cnt_d = car_cnt_q + CarCntW'(1);
        car_x_d   = car_x_q;
        if (car_cnt_q == CarCntW'(c_CAR_SLOW_COUNT - 1)) begin
            car_cnt_d = '0;
            if (int'(car_x_q) + c_CAR_SPEED >= c_CAR_MAX_X) begin
                car_x_d = 6'(c_CAR_INIT_X);
            end else begin
                car_x_d = car_x_q + 6'(c_CAR_SPEED);
            end
        end
    end

    // Log wraps back to its start column rather than stepping below the floor.
    always_comb begin
        log_cnt_d = log_cnt_q + LogCntW'(1);
        log_x_d   = log_x_q;
        if (log_cnt_q == LogCntW'(c_LOG_SLOW_COUNT - 1)) begin
            log_cnt_d = '0;
            if (int'(log_x_q) <= c_LOG_MIN_X + c_LOG_SPEED - 1) begin
                log_x_d = 6'(c_LOG_INIT_X);
            end else begin
                log_x_d = log_x_q - 6'(c_LOG_SPEED);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            col_q     <= '0;
            row_q     <= '0;
            car_cnt_q <= '0;
            log_cnt_q <= '0;
            car_x_q   <= 6'(c_CAR_INIT_X);
            log_x_q   <= 6'(c_LOG_INIT_X);
        end else begin
            hsync_q   <= i_HSync;
            vsync_q   <= i_VSync;
            col_q     <= col_d;
            row_q     <= row_d;
            car_cnt_q <= car_cnt_d;
            log_cnt_q <= log_cnt_d;
            car_x_q   <= car_x_d;
            log_x_q   <= log_x_d;
        end
    end

    assign o_HSync         = hsync_q;
    assign o_VSync         = vsync_q;
    assign o_Col_Count     = col_q;
    assign o_Row_Count     = row_q;
    assign o_Col_Count_Div = col_q[9:5];
    assign o_Row_Count_Div = row_q[9:5];
    assign o_Car_X         = car_x_q;
    assign o_Car_Y         = 6'(c_CAR_INIT_Y);
    assign o_Log_X         = log_x_q;
    assign o_Log_Y         = 6'(c_LOG_INIT_Y);
    assign o_Car_Draw      = ({1'b0, col_q[9:5]} == car_x_q) && ({1'b0, row_q[9:5]} == o_Car_Y);
    assign o_Log_Draw      = ({1'b0, col_q[9:5]} == log_x_q) && ({1'b0, row_q[9:5]} == o_Log_Y);

endmodule

// File: tb/tb_frogger_scan_obstacles.sv
// Directed bench: small-geometry instance for counting/motion, tile instance for draw flags,
// default instance for reset values.
module tb_frogger_scan_obstacles;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic hsync = 1'b0;
    logic vsync = 1'b0;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Instance A: tiny frame, fast obstacles
    logic       a_hs, a_vs, a_cd, a_ld;
    logic [9:0] a_col, a_row;
    logic [4:0] a_cdv, a_rdv;
    logic [5:0] a_cx, a_cy, a_lx, a_ly;

    frogger_scan_obstacles #(
        .c_TOTAL_COLS(8), .c_TOTAL_ROWS(4),
        .c_CAR_SLOW_COUNT(3), .c_CAR_MAX_X(4),
        .c_LOG_SLOW_COUNT(2), .c_LOG_INIT_X(3), .c_LOG_MIN_X(0)
    ) u_a (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(hsync), .i_VSync(vsync),
        .o_HSync(a_hs), .o_VSync(a_vs), .o_Col_Count(a_col), .o_Row_Count(a_row),
        .o_Col_Count_Div(a_cdv), .o_Row_Count_Div(a_rdv),
        .o_Car_X(a_cx), .o_Car_Y(a_cy), .o_Log_X(a_lx), .o_Log_Y(a_ly),
        .o_Car_Draw(a_cd), .o_Log_Draw(a_ld)
    );

    // Instance B: full frame, log parked at (1,1), car at (0,1)
    logic       b_hs, b_vs, b_cd, b_ld;
    logic [9:0] b_col, b_row;
    logic [4:0] b_cdv, b_rdv;
    logic [5:0] b_cx, b_cy, b_lx, b_ly;

    frogger_scan_obstacles #(
        .c_LOG_INIT_X(1), .c_CAR_INIT_Y(1)
    ) u_b (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(hsync), .i_VSync(vsync),
        .o_HSync(b_hs), .o_VSync(b_vs), .o_Col_Count(b_col), .o_Row_Count(b_row),
        .o_Col_Count_Div(b_cdv), .o_Row_Count_Div(b_rdv),
        .o_Car_X(b_cx), .o_Car_Y(b_cy), .o_Log_X(b_lx), .o_Log_Y(b_ly),
        .o_Car_Draw(b_cd), .o_Log_Draw(b_ld)
    );

    // Instance C: default parameters
    logic       c_hs, c_vs, c_cd, c_ld;
    logic [9:0] c_col, c_row;
    logic [4:0] c_cdv, c_rdv;
    logic [5:0] c_cx, c_cy, c_lx, c_ly;

    frogger_scan_obstacles u_c (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_HSync(hsync), .i_VSync(vsync),
        .o_HSync(c_hs), .o_VSync(c_vs), .o_Col_Count(c_col), .o_Row_Count(c_row),
        .o_Col_Count_Div(c_cdv), .o_Row_Count_Div(c_rdv),
        .o_Car_X(c_cx), .o_Car_Y(c_cy), .o_Log_X(c_lx), .o_Log_Y(c_ly),
        .o_Car_Draw(c_cd), .o_Log_Draw(c_ld)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check("rst_a_col", a_col, 0);
        check("rst_a_row", a_row, 0);
        check("rst_a_hs", a_hs, 0);
        check("rst_a_vs", a_vs, 0);
        check("rst_c_car_x", c_cx, 0);
        check("rst_c_car_y", c_cy, 11);
        check("rst_c_log_x", c_lx, 13);
        check("rst_c_log_y", c_ly, 1);
        check("rst_a_log_x", a_lx, 3);

        @(negedge clk);
        rst_n = 1'b1;

        // k = posedges since release
        for (int k = 1; k <= 32; k++) begin
            step(1);
            check("a_col", a_col, k % 8);
            check("a_row", a_row, (k / 8) % 4);
            check("a_car_x", a_cx, (k / 3) % 4);
            check("a_car_y", a_cy, 11);
            check("a_log_x", a_lx, 3 - ((k / 2) % 4));
        end

        // sync re-time
        hsync = 1'b1;
        #2;
        check("hs_before_edge", a_hs, 0);
        step(1);
        check("hs_after_edge", a_hs, 1);
        hsync = 1'b0;
        step(1);
        check("hs_fall", a_hs, 0);

        // now k = 34; reach col=5,row=2 at k=53
        step(19);
        check("pre_fs_col", a_col, 5);
        check("pre_fs_row", a_row, 2);
        vsync = 1'b1;
        #2;
        check("vs_before_edge", a_vs, 0);
        step(1);
        check("fs_col", a_col, 0);
        check("fs_row", a_row, 0);
        check("fs_vs", a_vs, 1);
        step(1);
        check("vs_held_col", a_col, 1);
        check("vs_held_row", a_row, 0);

        // fresh frame start to align instance B
        vsync = 1'b0;
        step(1);
        vsync = 1'b1;
        step(1);
        check("b_fs_col", b_col, 0);
        check("b_fs_row", b_row, 0);
        vsync = 1'b0;

        step(32 * 800 + 16);
        check("b_col16", b_col, 16);
        check("b_row32", b_row, 32);
        check("b_car_draw_t0", b_cd, 1);
        check("b_log_draw_t0", b_ld, 0);
        step(16);
        check("b_col32", b_col, 32);
        check("b_col_div", b_cdv, 1);
        check("b_row_div", b_rdv, 1);
        check("b_log_draw_t1", b_ld, 1);
        check("b_car_draw_t1", b_cd, 0);
        step(32);
        check("b_col64", b_col, 64);
        check("b_log_draw_t2", b_ld, 0);

        // mid-run async reset
        rst_n = 1'b0;
        #1;
        check("mrst_col", a_col, 0);
        check("mrst_row", a_row, 0);
        check("mrst_vs", a_vs, 0);
        check("mrst_log_x", a_lx, 3);
        check("mrst_b_col", b_col, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);
        check("post_rst_col", a_col, 1);
        check("post_rst_car", a_cx, 0);
        step(2);
        check("post_rst_car_tick", a_cx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/frogger_scan_obstacles.md
Name: frogger_scan_obstacles

Overview:
- Combines VGA scan-position tracking with the movement of one road car and one floating log.
- Regenerates column/row counters from incoming HSync/VSync and re-times the syncs.
- Moves a car rightward and a log leftward, one tile per slow-tick, on fixed rows.
- Sits between the VGA sync generator and the game renderer/collision logic; outputs tile coordinates and per-pixel draw flags.

Parameters:
- c_TOTAL_COLS, 800, total columns per line including blanking
- c_TOTAL_ROWS, 525, total rows per frame including blanking
- c_CAR_SPEED, 1, tiles the car advances per car tick
- c_CAR_MAX_X, 14, car column limit (exclusive)
- c_CAR_SLOW_COUNT, 4000000, clocks per car tick
- c_CAR_INIT_X, 0, car reset/wrap column
- c_CAR_INIT_Y, 11, car row (constant)
- c_LOG_SPEED, 1, tiles the log retreats per log tick
- c_LOG_MIN_X, 0, log column floor
- c_LOG_SLOW_COUNT, 4200000, clocks per log tick
- c_LOG_INIT_X, 13, log reset/wrap column
- c_LOG_INIT_Y, 1, log row (constant)

Ports:
- i_Clk, in, 1, system/pixel clock
- i_Rst_L, in, 1, reset: asynchronous, active-low
- i_HSync, in, 1, horizontal sync from generator
- i_VSync, in, 1, vertical sync from generator
- o_HSync, out, 1, i_HSync delayed one clock
- o_VSync, out, 1, i_VSync delayed one clock
- o_Col_Count, out, 10, current column
- o_Row_Count, out, 10, current row
- o_Col_Count_Div, out, 5, o_Col_Count[9:5] (tile column)
- o_Row_Count_Div, out, 5, o_Row_Count[9:5] (tile row)
- o_Car_X / o_Car_Y, out, 6 each, car tile position
- o_Log_X / o_Log_Y, out, 6 each, log tile position
- o_Car_Draw, out, 1, current tile equals car tile
- o_Log_Draw, out, 1, current tile equals log tile

Behaviour:
- Reset (i_Rst_L=0, async):
  - o_HSync = o_VSync = 0; counters = 0.
  - Car X = c_CAR_INIT_X; log X = c_LOG_INIT_X.
  - Both slow counters = 0.
- Sync re-time: o_HSync/o_VSync register i_HSync/i_VSync every clock; 1-cycle latency.
- Frame start = i_VSync & ~o_VSync (rising edge, combinational).
  - On frame start: col = 0 and row = 0 next clock; overrides normal counting.
- Otherwise:
  - col increments by 1; at c_TOTAL_COLS-1, col wraps to 0 and row increments.
  - Row at c_TOTAL_ROWS-1 with col at c_TOTAL_COLS-1 wraps to 0.
- Div outputs are pure combinational slices of the counter registers.
- Car tick:
  - Slow counter counts 0..c_CAR_SLOW_COUNT-1; on reaching the terminal value, it returns to 0 and the car moves.
  - Move: if X + c_CAR_SPEED >= c_CAR_MAX_X, then X = c_CAR_INIT_X; else X = X + c_CAR_SPEED.
  - o_Car_Y is constant c_CAR_INIT_Y.
- Log tick: same slow-counter scheme with c_LOG_SLOW_COUNT.
  - Move: if X <= c_LOG_MIN_X + c_LOG_SPEED - 1 (i.e. would go below min), X = c_LOG_INIT_X; else X = X - c_LOG_SPEED.
  - o_Log_Y is constant c_LOG_INIT_Y.
- Slow counters run continuously, independent of sync inputs; 23 bits minimum (size from parameters).
- Draw flags (combinational):
  - o_Car_Draw = ({1'b0,Col_Div}==Car_X) && ({1'b0,Row_Div}==Car_Y); log likewise.
- Reset asserted mid-frame or mid-tick restores all state at once; counting resumes on the first clock after release.

Test Plan:
- Reset: hold i_Rst_L=0 -> o_Col/Row_Count=0, o_HSync=o_VSync=0, Car=(0,11), Log=(13,1); release -> col counts 1,2,3…
- Counter wrap (c_TOTAL_COLS=8, c_TOTAL_ROWS=4, VSync held 0):
  - after 8 clocks col=0, row=1;
  - after 32 clocks col=0, row=0.
- Frame start: raise i_VSync at col=5, row=2 -> next clock col=0, row=0; o_VSync rises the same edge; holding VSync high does not re-zero.
- Car motion (c_CAR_SLOW_COUNT=3, c_CAR_MAX_X=4):
  - X sequence 0,1,2,3,0 changing every 3 clocks;
  - o_Car_Y stays 11.
- Log motion (c_LOG_SLOW_COUNT=2, c_LOG_INIT_X=3, c_LOG_MIN_X=0): X sequence 3,2,1,0,3 changing every 2 clocks.
- Draw flags:
  - col count=32 (tile 1), row count=32 (tile 1) with log at (1,1) -> o_Log_Draw=1, o_Car_Draw=0;
  - col count=64 -> o_Log_Draw=0.
